// File: rtl/fu_cmpl_queue_pkg.sv
// Shared completion-packet definitions for the FU completion queue.
// Provides `ROB_IDX_W (if not already set), source index macros and cmpl_pkt_t.
`ifndef ROB_IDX_W
`define ROB_IDX_W 6
`endif

`ifndef CMPL_SRC_BR
`define CMPL_SRC_BR   0
`define CMPL_SRC_MULT 1
`define CMPL_SRC_ALU  2
`endif

package fu_cmpl_queue_pkg;

    typedef struct packed {
        logic [`ROB_IDX_W-1:0] rob_idx;
        logic                  is_br;
        logic                  br_taken;
        logic [63:0]           br_target;
    } cmpl_pkt_t;

endpackage

// File: rtl/fu_cmpl_compact.sv
// Priority compaction of per-source completion packets into ordered slots.
// Ports: done_i/pkt_i per source in; slot_o ordered packets, enq_n_o count out.
module fu_cmpl_compact
    import fu_cmpl_queue_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int CNT_W   = 4
) (
    input  logic [NUM_SRC-1:0] done_i,
    input  cmpl_pkt_t          pkt_i [NUM_SRC],
    output cmpl_pkt_t          slot_o [NUM_SRC],
    output logic [CNT_W-1:0]   enq_n_o
);

    always_comb begin
        int        k;
        cmpl_pkt_t p;
        k = 0;
        p = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            slot_o[i] = '0;
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (done_i[i]) begin
                p = pkt_i[i];
                // Branch fields only carry meaning for branch resolutions.
                if (!p.is_br) begin
                    p.br_taken  = 1'b0;
                    p.br_target = '0;
                end
                slot_o[k] = p;
                k = k + 1;
            end
        end
        enq_n_o = CNT_W'(k);
    end

endmodule

// File: rtl/fu_cmpl_queue.sv
// Completion queue between the FU cluster and the ROB: compacts, buffers, presents.
// Ports: fu_* completions in, rob_flush_i/rob_rdy_i, cmpl_* head/stall/ovf out.
// Optional FU_CMPL_BYPASS_EN: single completion into empty queue bypasses storage.
module fu_cmpl_queue
    import fu_cmpl_queue_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int NUM_SRC = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_SRC-1:0]              fu_done_i,
    input  logic [NUM_SRC*`ROB_IDX_W-1:0]   fu_rob_idx_i,
    input  logic [NUM_SRC-1:0]              fu_br_taken_i,
    input  logic [NUM_SRC*64-1:0]           fu_br_target_i,
    input  logic [NUM_SRC-1:0]              fu_is_br_i,
    input  logic                            rob_flush_i,
    input  logic                            rob_rdy_i,
    output logic                            cmpl_vld_o,
    output logic [`ROB_IDX_W-1:0]           cmpl_rob_idx_o,
    output logic                            cmpl_br_taken_o,
    output logic [63:0]                     cmpl_br_target_o,
    output logic                            cmpl_stall_o,
    output logic                            cmpl_ovf_o
);

    localparam int RW = `ROB_IDX_W;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    cmpl_pkt_t         mem_q [DEPTH];
    cmpl_pkt_t         mem_d [DEPTH];
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic              stall_q, stall_d;
    logic              ovf_q, ovf_d;

    cmpl_pkt_t         pkt_in [NUM_SRC];
    cmpl_pkt_t         slot [NUM_SRC];
    logic [CW-1:0]     enq_n;
    logic [CW-1:0]     room;
    logic [CW-1:0]     acc_n;
    logic              deq;
    logic              byp;
    cmpl_pkt_t         head_pkt;

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            pkt_in[i].rob_idx   = fu_rob_idx_i[i*RW +: RW];
            pkt_in[i].is_br     = fu_is_br_i[i];
            pkt_in[i].br_taken  = fu_br_taken_i[i];
            pkt_in[i].br_target = fu_br_target_i[i*64 +: 64];
        end
    end

    fu_cmpl_compact #(
        .NUM_SRC (NUM_SRC),
        .CNT_W   (CW)
    ) u_compact (
        .done_i  (fu_done_i),
        .pkt_i   (pkt_in),
        .slot_o  (slot),
        .enq_n_o (enq_n)
    );

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        byp     = 1'b0;
        deq     = (count_q != '0) && rob_rdy_i;
        // A dequeue this cycle frees one slot for an arriving packet.
        room    = CW'(DEPTH) - count_q + CW'(deq);
        acc_n   = (enq_n > room) ? room : enq_n;
`ifdef FU_CMPL_BYPASS_EN
        byp = (count_q == '0) && (enq_n == CW'(1)) && !rob_flush_i;
        if (byp && rob_rdy_i) begin
            acc_n = '0;
        end
`endif
        if (enq_n > room) begin
            ovf_d = 1'b1;
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (CW'(i) < acc_n) begin
                mem_d[tail_q + PW'(i)] = slot[i];
            end
        end
        tail_d  = tail_q + PW'(acc_n);
        head_d  = head_q + PW'(deq);
        count_d = count_q + acc_n - CW'(deq);
        if (rob_flush_i) begin
            mem_d   = mem_q;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            ovf_d   = ovf_q;
        end
        stall_d = (CW'(DEPTH) - count_d) < CW'(2 * NUM_SRC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            stall_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            stall_q <= stall_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        head_pkt   = byp ? slot[0] : mem_q[head_q];
        cmpl_vld_o = (count_q != '0) || byp;
    end

    assign cmpl_rob_idx_o   = head_pkt.rob_idx;
    assign cmpl_br_taken_o  = head_pkt.is_br & head_pkt.br_taken;
    assign cmpl_br_target_o = head_pkt.br_target;
    assign cmpl_stall_o     = stall_q;
    assign cmpl_ovf_o       = ovf_q;

endmodule
